// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the core-side memory bus: source IDs, access sizes
// and the arbiter state encoding.
package cpu_bus_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/id_fifo.sv
// Small FIFO of 1-bit source IDs, one entry per accepted-but-unanswered
// memory request. Head is read combinationally so responses route same-cycle.
module id_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push_i,
  input  logic          push_id_i,
  input  logic          pop_i,
  output logic          head_id_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = CW - 1;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          id_mem_q [DEPTH];

  // Payload needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (push_i) id_mem_q[wr_ptr_q] <= push_id_i;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign head_id_o = id_mem_q[rd_ptr_q];
  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/mem_port_arb.sv
// Shares one SRAM-like port between the IF and EX/MEM requesters; holds the
// grant until accepted and routes in-order responses back by source ID.
module mem_port_arb
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int STREAK = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STREAK + 1);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          err_q, err_d;
  logic          grant_valid, grant_src, accept, resp_valid;
  logic          fifo_full, fifo_empty, fifo_head;
  logic [CW-1:0] fifo_count_unused;

  always_comb begin
    state_d     = state_q;
    grant_valid = 1'b0;
    grant_src   = SRC_DATA;
    unique case (state_q)
      ARB_IDLE: begin
        if (!fifo_full) begin
          // Data normally wins; a saturated streak lets a waiting fetch through.
          if (inst_req && (streak_q == SW'(STREAK))) begin
            grant_valid = 1'b1;
            grant_src   = SRC_INST;
          end else if (data_req) begin
            grant_valid = 1'b1;
            grant_src   = SRC_DATA;
          end else if (inst_req) begin
            grant_valid = 1'b1;
            grant_src   = SRC_INST;
          end
        end
      end
      ARB_HOLD_I: begin
        grant_valid = 1'b1;
        grant_src   = SRC_INST;
      end
      ARB_HOLD_D: begin
        grant_valid = 1'b1;
        grant_src   = SRC_DATA;
      end
      default: state_d = ARB_IDLE;
    endcase
    accept = grant_valid && mem_addr_ok;
    if (grant_valid) begin
      if (mem_addr_ok)                 state_d = ARB_IDLE;
      else if (grant_src == SRC_INST)  state_d = ARB_HOLD_I;
      else                             state_d = ARB_HOLD_D;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_valid) begin
      mem_req = 1'b1;
      if (grant_src == SRC_INST) begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end else begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!inst_req) begin
      streak_d = '0;
    end else if (accept) begin
      if (grant_src == SRC_INST)          streak_d = '0;
      else if (streak_q != SW'(STREAK))   streak_d = streak_q + 1'b1;
    end
  end

  assign inst_addr_ok = accept && (grant_src == SRC_INST);
  assign data_addr_ok = accept && (grant_src == SRC_DATA);

  // A response with nothing outstanding is dropped and flagged instead.
  assign resp_valid   = mem_data_ok && !fifo_empty;
  assign inst_data_ok = resp_valid && (fifo_head == SRC_INST);
  assign data_data_ok = resp_valid && (fifo_head == SRC_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;
  assign err_d        = err_q | (mem_data_ok & fifo_empty);
  assign err          = err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ARB_IDLE;
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      err_q    <= err_d;
    end
  end

  id_fifo #(
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push_i    (accept),
    .push_id_i (grant_src),
    .pop_i     (resp_valid),
    .head_id_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count_unused)
  );

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Arbiter that shares a single SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (EX/MEM stages) of the 5-stage pipeline. It selects one request per cycle, holds the selection stable until the memory accepts it, and tracks the source of every outstanding request so that in-order responses return to the correct requester. It sits between the core (`mycpu_top` pipeline) and the downstream memory bridge.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `DEPTH`, 4, max outstanding accepted-but-unanswered requests (power of 2, ≥2)
- `STREAK`, 4, max consecutive data grants while an inst request waits
- `clk`  in  1  clock
- `resetn`  in  1  async active-low reset
- `inst_req`, `inst_wr`  in  1 each  inst request / write flag
- `inst_size`  in  2  0=byte 1=half 2=word
- `inst_wstrb`  in  4; `inst_addr`  in  ADDR_W; `inst_wdata`  in  DATA_W
- `inst_addr_ok`, `inst_data_ok`  out  1 each; `inst_rdata`  out  DATA_W
- `data_req`, `data_wr`, `data_size`, `data_wstrb`, `data_addr`, `data_wdata`  in  (same widths); `data_addr_ok`, `data_data_ok`  out  1; `data_rdata`  out  DATA_W
- `mem_req`, `mem_wr`  out  1; `mem_size`  out  2; `mem_wstrb`  out  4; `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W
- `mem_addr_ok`, `mem_data_ok`  in  1; `mem_rdata`  in  DATA_W
- `err`  out  1  sticky: `mem_data_ok` while no request outstanding

## Operation
- States: IDLE, HOLD_I, HOLD_D.
- IDLE: if outstanding count < DEPTH, pick a source: data wins unless `inst_req` is high and streak counter == STREAK, in which case inst wins. The winner drives the mem_* fields combinationally; `mem_req`=1.
  - `mem_addr_ok`=1 same cycle: request accepted, stay IDLE.
  - otherwise go to HOLD_I / HOLD_D (grant locked).
- HOLD_x: mem_* driven from source x only; the other requester never sees addr_ok. Go to IDLE on `mem_addr_ok`. Requesters keep `req` and fields stable until addr_ok (core contract); the arbiter does not re-arbitrate.
- On acceptance: push source ID (0=inst, 1=data) into the ID FIFO; forward `mem_addr_ok` to the winner's `*_addr_ok` only.
- Streak: +1 (saturating at STREAK) on each accepted data request while `inst_req`=1; cleared on any accepted inst request or whenever `inst_req`=0.
- On `mem_data_ok`: pop FIFO; assert `*_data_ok` of the head ID, `*_rdata`=`mem_rdata` for that source; the other source's rdata is 0.
- Full (count==DEPTH): `mem_req`=0 in IDLE, no `*_addr_ok`. Push and pop in the same cycle are both legal when not full; count unchanged.
- Empty + `mem_data_ok`: no output pulse, `err` set until reset.

## Timing
- Reset (async, `resetn`=0): state IDLE, FIFO empty, streak 0, `err`=0; all outputs 0.
- Request path combinational: request in cycle N can get addr_ok in cycle N (zero added latency).
- Response path combinational: `*_data_ok` in the same cycle as `mem_data_ok`.
- Outstanding count, streak, state, FIFO update on rising `clk`.
- Reset mid-transaction drops all tracking; in-flight responses after reset raise `err`.

## Structure
- Package `cpu_bus_pkg`: `SRC_INST`=0, `SRC_DATA`=1, size encodings `SZ_BYTE/SZ_HALF/SZ_WORD`, state enum.
- Sub-module `id_fifo`: DEPTH×1-bit FIFO with push/pop, full/empty, count; pointers wrap modulo DEPTH.

## Test plan
- Single inst read, addr 0x1C000000, `mem_addr_ok` same cycle, `mem_data_ok` 2 cycles later with 0x02800C0C -> `inst_addr_ok` cycle 0, `inst_data_ok`=1 and `inst_rdata`=0x02800C0C cycle 2, data side silent.
- Both request simultaneously, data addr 0x100, inst addr 0x1C000004 -> data granted first; with `mem_addr_ok` delayed 3 cycles, mem_addr stays 0x100 throughout, then inst issued; responses route data then inst.
- Data `req` held high for 6 accepts with inst pending, STREAK=4 -> 4 data grants, then 1 inst grant, then data resumes.
- Issue 4 accepted requests without responses (DEPTH=4) -> 5th sees `mem_req`=0; one `mem_data_ok` same cycle as new acceptance is not possible when full; after pop, next request accepted.
- Interleaved sources, responses returned in order with values 0x1,0x2,0x3 -> each `*_data_ok` matches issue order; FIFO pointer wrap after 6 transactions verified.
- `mem_data_ok` with FIFO empty -> no `*_data_ok`, `err`=1 held; assert `resetn`=0 -> `err`=0 asynchronously.
